// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streaming block: default sizes,
// the skid-buffer state encoding and a helper that maps a state to its
// occupancy.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEFAULT = 16;
  localparam int FIFO_DEPTH_DEFAULT = 2;
  localparam int STAT_W_DEFAULT     = 16;

  // Occupancy limit of the skid buffer, in the 2-bit occupancy width.
  localparam logic [1:0] SKID_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } skid_state_e;

  // Number of words held in the buffer for a given state.
  function automatic logic [1:0] state_occ(input skid_state_e st);
    logic [1:0] occ;
    case (st)
      IDLE:    occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer. The head register drives the stream data; the
// tail register only holds a word while the buffer is full. The caller must
// never push into a full buffer without popping in the same cycle, and must
// never pop an empty buffer.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FIFO_WIDTH-1:0] push_data,
  output logic [FIFO_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  skid_state_e           state_q, state_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;

  // Next-state and datapath: the oldest word always sits in the head register.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      IDLE: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end else begin
          state_d = IDLE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = TWO;
        end else if (pop) begin
          state_d = IDLE;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        if (push && pop) begin
          head_d = tail_q;
          tail_d = push_data;
        end else if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q  <= {FIFO_WIDTH{1'b0}};
      tail_q  <= {FIFO_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head_data = head_q;
  assign occ       = state_occ(state_q);

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns the read port of a FIFO with one-cycle read latency into a
// valid/ready stream. Reads are issued only when the word they return is
// guaranteed a slot in the 2-entry skid buffer, which gives one word per
// cycle under continuous flow and no loss under backpressure.
// Optional feature: define FIFO_RD_STREAM_STATS_EN to add the word_cnt
// delivered-word counter and its output port.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int STAT_W     = STAT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef FIFO_RD_STREAM_STATS_EN
  output logic [STAT_W-1:0]     word_cnt,
`endif
  output logic                  err_underflow
);

  logic       infl_q, infl_d;
  logic       start_q, start_d;
  logic       err_q, err_d;
  logic       pop_s;
  logic [1:0] occ_s;
  logic [1:0] occ_after_s;

  fifo_rd_skid #(
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_q),
    .pop       (pop_s),
    .push_data (fifo_data_out),
    .head_data (m_data),
    .occ       (occ_s)
  );

  assign m_valid = (occ_s != 2'd0);

  // Read request: a slot must remain for the returning word, counting this
  // cycle's pop. start_q holds reads off until the first edge after reset.
  always_comb begin
    pop_s       = m_valid && m_ready;
    occ_after_s = occ_s - {1'b0, pop_s};
    if (start_q && !fifo_empty && ((occ_after_s + {1'b0, infl_q}) < SKID_DEPTH)) begin
      fifo_rd_en = 1'b1;
    end else begin
      fifo_rd_en = 1'b0;
    end
  end

  // Next values: in-flight tracks the accepted read, error flag is sticky.
  always_comb begin
    infl_d  = fifo_rd_en;
    start_d = 1'b1;
    if (fifo_underflow) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Control registers; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      infl_q  <= infl_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign err_underflow = err_q;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STAT_W-1:0] word_cnt_q, word_cnt_d;

  // Delivered-word count, wrapping naturally at the counter width.
  always_comb begin
    if (pop_s) begin
      word_cnt_d = word_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= {STAT_W{1'b0}};
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural upstream FIFO with one-cycle read
// latency, a vector table for the backpressure sequence and hand-written
// sequences for streaming, empty boundary, underflow, reset and wrap.
// Word-count checks are compiled in with FIFO_RD_STREAM_STATS_EN.
module tb_fifo_rd_stream;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic          fifo_underflow = 1'b0;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_rd_en;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          err_underflow;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [SW-1:0] word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .FIFO_WIDTH (W),
    .STAT_W     (SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
`ifdef FIFO_RD_STREAM_STATS_EN
    .word_cnt       (word_cnt),
`endif
    .err_underflow  (err_underflow)
  );

  // Upstream FIFO model: data appears on the edge that accepts the read.
  logic [W-1:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_empty_viol = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= fmem[rd_ptr[5:0]];
      rd_ptr        <= rd_ptr + 1;
    end
    if (fifo_rd_en && fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fmem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_ready = 1'b0;
    fifo_underflow = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         m_ready;
    logic         exp_rd_en;
    logic         exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int first_rd;
    int first_valid;
    int got;
    int pulses;
    int xfers;
    logic [W-1:0] base;

    // Backpressure table: words B001..B004, m_ready low for 12 samples.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000};
    for (int i = 3; i < 12; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 16'hB001};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 16'hB001};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 16'hB002};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 16'hB003};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 16'hB004};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 16'h0000};

    // Reset state, sampled while rst_n is low.
    #1;
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_data", m_data, 16'h0000);
    check("reset_rd_en", fifo_rd_en, 1'b0);
    check("reset_err", err_underflow, 1'b0);

    // Streaming: A001..A008 with m_ready held high.
    do_reset();
    base = 16'hA001;
    for (int i = 0; i < 8; i++) push_word(base + i[W-1:0]);
    m_ready = 1'b1;
    first_rd = -1;
    first_valid = -1;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      if (m_valid) begin
        if (got == 0) begin
          first_valid = c;
          check("stream_latency", c - first_rd, 2);
        end
        check("stream_data", m_data, base + got[W-1:0]);
        check("stream_consecutive", c - first_valid, got);
        got++;
      end
      @(negedge clk);
    end
    check("stream_count", got, 8);
    check("stream_idle_after", m_valid, 1'b0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("stream_word_cnt", word_cnt, 4'd8);
`endif

    // Backpressure sequence driven from the table.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(16'hB001 + i[W-1:0]);
    for (int i = 0; i < 17; i++) begin
      m_ready = tbl[i].m_ready;
      #1;
      check($sformatf("bp_rd_en[%0d]", i), fifo_rd_en, tbl[i].exp_rd_en);
      check($sformatf("bp_valid[%0d]", i), m_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check($sformatf("bp_data[%0d]", i), m_data, tbl[i].exp_data);
      @(negedge clk);
    end

    // Empty boundary: a single word 00FF.
    do_reset();
    push_word(16'h00FF);
    m_ready = 1'b1;
    pulses = 0;
    xfers = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fifo_rd_en) pulses++;
      if (m_valid && m_ready) begin
        xfers++;
        check("empty_data", m_data, 16'h00FF);
      end
      @(negedge clk);
    end
    #1;
    check("empty_rd_pulses", pulses, 1);
    check("empty_xfers", xfers, 1);
    check("empty_rd_en_low", fifo_rd_en, 1'b0);
    check("empty_no_underflow", err_underflow, 1'b0);

    // Underflow flag is sticky until reset.
    @(negedge clk);
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("uf_sticky[%0d]", c), err_underflow, 1'b1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("uf_cleared_by_reset", err_underflow, 1'b0);

    // Reset while C002 is in flight: it must never be delivered.
    do_reset();
    for (int i = 0; i < 3; i++) push_word(16'hC001 + i[W-1:0]);
    repeat (2) @(negedge clk);
    #1;
    check("mid_rd_en_before", fifo_rd_en, 1'b1);
    @(negedge clk);
    #1;
    check("mid_valid_before", m_valid, 1'b1);
    check("mid_data_before", m_data, 16'hC001);
    rst_n = 1'b0;
    #1;
    check("mid_valid_async", m_valid, 1'b0);
    check("mid_data_async", m_data, 16'h0000);
    check("mid_rd_en_async", fifo_rd_en, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_valid_after", m_valid, 1'b0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("mid_word_cnt", word_cnt, 4'd0);
`endif
    m_ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (m_valid) begin
        xfers++;
        check("mid_data_after", m_data, 16'hC003);
      end
      @(negedge clk);
    end
    check("mid_xfers", xfers, 1);

    // Wrap: 17 words through a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push_word(16'hD000 + i[W-1:0]);
    m_ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (m_valid && m_ready) begin
        check("wrap_data", m_data, 16'hD000 + xfers[W-1:0]);
        xfers++;
      end
      @(negedge clk);
    end
    check("wrap_xfers", xfers, 17);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("wrap_word_cnt", word_cnt, 4'd1);
`endif

    check("rd_en_while_empty", rd_empty_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
